// File: rtl/music_pkg.sv
// Shared types and pitch table for the background-music player.
// Pitch table: one octave of base half-periods at 50 MHz, scaled per octave.
package music_pkg;

  localparam logic [7:0] NOTE_REST = 8'd0;
  localparam int HP_W = 20;

  typedef logic [HP_W-1:0] hp_t;
  typedef logic [255:0][HP_W-1:0] hp_lut_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    PLAY,
    DONE
  } state_t;

  // Code 33 = C4, 18 steps per octave; codes 0 and 128..255 are rests.
  function automatic hp_t half_period(input int n, input longint clk_hz);
    longint base;
    longint num;
    longint den;
    int d;
    int o;
    if (n < 1 || n > 127) return '0;
    d = n + 3;
    o = d / 18 - 2;
    case (d % 18)
      0:  base = 95555;
      1:  base = 91945;
      2:  base = 88472;
      3:  base = 85130;
      4:  base = 81914;
      5:  base = 78819;
      6:  base = 75842;
      7:  base = 72977;
      8:  base = 70220;
      9:  base = 67567;
      10: base = 65015;
      11: base = 62559;
      12: base = 60196;
      13: base = 57922;
      14: base = 55734;
      15: base = 53628;
      16: base = 51602;
      17: base = 49653;
      default: base = 0;
    endcase
    num = base * clk_hz;
    den = 64'd50_000_000;
    if (o < 0) num = num << (-o);
    else den = den << o;
    return hp_t'((num + den / 2) / den);
  endfunction

  function automatic hp_lut_t half_period_lut(input longint clk_hz);
    hp_lut_t t;
    t = '0;
    for (int n = 0; n < 256; n++) t[n] = half_period(n, clk_hz);
    return t;
  endfunction

endpackage

// File: rtl/music_player_note_tone_gen.sv
// Square-wave generator: toggles the speaker every hp clock cycles.
module note_tone_gen
  import music_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [HP_W-1:0] hp,
  output logic            speaker
);

  hp_t tone_cnt;

  // en low freezes the phase counter but silences the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      tone_cnt <= '0;
      speaker  <= 1'b0;
    end else if (!en) begin
      speaker <= 1'b0;
    end else if (hp == '0) begin
      tone_cnt <= '0;
      speaker  <= 1'b0;
    end else if (tone_cnt == hp - hp_t'(1)) begin
      tone_cnt <= '0;
      speaker  <= ~speaker;
    end else begin
      tone_cnt <= tone_cnt + hp_t'(1);
    end
  end

endmodule

// File: rtl/music_player.sv
// Song sequencer: walks the note ROM at a fixed tempo and drives the buzzer.
module music_player
  import music_pkg::*;
#(
  parameter int      CLK_HZ         = 50_000_000,
  parameter int      TICKS_PER_STEP = 6_250_000,
  parameter int      GAP_TICKS      = 500_000,
  parameter int      SONG_LEN       = 176,
  parameter int      ADDR_W         = 8,
  parameter hp_lut_t HP_LUT         = half_period_lut(CLK_HZ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              restart,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_note,
  output logic              speaker,
  output logic [7:0]        cur_note,
  output logic              busy,
  output logic              done
);

  localparam int STEP_W = $clog2(TICKS_PER_STEP);
  localparam logic [STEP_W-1:0] STEP_LAST =
    STEP_W'(TICKS_PER_STEP - 1);
  localparam logic [STEP_W-1:0] TONE_END =
    STEP_W'(TICKS_PER_STEP - GAP_TICKS);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [STEP_W-1:0] step_cnt;
  hp_t               hp;
  logic              run;
  logic              step_end;
  logic              tone_win;
  logic              tone_en;
  logic              tone_out;

  assign run      = (state == PLAY) && play;
  assign step_end = run && (step_cnt == STEP_LAST);
  assign tone_win = (state == PLAY) && (hp != '0) &&
                    (step_cnt < TONE_END);
  assign tone_en  = !((state == PLAY) && !play);
  assign speaker  = tone_out && tone_win && play;
  assign busy     = (state == FETCH) || (state == WAIT) ||
                    (state == PLAY);
  assign done     = (state == DONE) && !restart;

  note_tone_gen u_tone (
    .clk     (clk),
    .rst     (rst),
    .en      (tone_en),
    .hp      (tone_win ? hp : hp_t'(0)),
    .speaker (tone_out)
  );

  always_comb begin
    state_n = state;
    addr_n  = rom_addr;
    if (restart) begin
      state_n = FETCH;
      addr_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (play) begin
            state_n = FETCH;
            addr_n  = '0;
          end
        end
        FETCH: state_n = WAIT;
        WAIT:  state_n = PLAY;
        PLAY: begin
          if (step_end) begin
            if (rom_addr < ADDR_LAST) begin
              addr_n  = rom_addr + ADDR_W'(1);
              state_n = FETCH;
            end else if (loop) begin
              addr_n  = '0;
              state_n = FETCH;
            end else begin
              state_n = DONE;
            end
          end
        end
        DONE: begin
          state_n = IDLE;
          addr_n  = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      step_cnt <= '0;
      hp       <= '0;
      cur_note <= NOTE_REST;
    end else begin
      state    <= state_n;
      rom_addr <= addr_n;
      if (state == WAIT && !restart) begin
        cur_note <= rom_note[7] ? NOTE_REST : rom_note;
        hp       <= HP_LUT[rom_note];
        step_cnt <= '0;
      end else if (run) begin
        step_cnt <= step_cnt + STEP_W'(1);
      end
      // Nothing sounds once the song has ended.
      if (state_n == DONE || state_n == IDLE) cur_note <= NOTE_REST;
    end
  end

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player with a tiny song and short tempo.
module tb_music_player;
  import music_pkg::*;

  function automatic hp_lut_t tb_lut();
    hp_lut_t t;
    t = '0;
    t[33] = 20'd3;
    t[51] = 20'd2;
    return t;
  endfunction

  localparam hp_lut_t TB_LUT = tb_lut();

  logic       clk;
  logic       rst;
  logic       play;
  logic       restart;
  logic       loop;
  logic [7:0] rom_addr;
  logic [7:0] rom_note;
  logic       speaker;
  logic [7:0] cur_note;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  logic [7:0]  rom_mem  [4] = '{8'd33, 8'd0, 8'd51, 8'd33};
  logic [7:0]  exp_note [4] = '{8'd33, 8'd0, 8'd51, 8'd33};
  logic [21:0] exp_spk  [4] =
    '{22'h0238E0, 22'h000000, 22'h033330, 22'h0238E0};

  music_player #(
    .CLK_HZ         (50_000_000),
    .TICKS_PER_STEP (20),
    .GAP_TICKS      (4),
    .SONG_LEN       (4),
    .ADDR_W         (8),
    .HP_LUT         (TB_LUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .play     (play),
    .restart  (restart),
    .loop     (loop),
    .rom_addr (rom_addr),
    .rom_note (rom_note),
    .speaker  (speaker),
    .cur_note (cur_note),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk)
    rom_note <= (rom_addr < 8'd4) ? rom_mem[rom_addr[1:0]] : 8'd0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (done === 1'b1) done_seen++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    play = 1'b0;
    restart = 1'b0;
    loop = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic cap_step(output logic [21:0] spk,
                          output logic [7:0] addr,
                          output logic [7:0] note,
                          output int busy_low);
    spk = '0;
    addr = '0;
    note = '0;
    busy_low = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      spk[i] = speaker;
      if (i == 0) addr = rom_addr;
      if (i == 2) note = cur_note;
      if (busy !== 1'b1) busy_low++;
    end
  endtask

  task automatic wait_addr(input logic [7:0] target, input int max,
                           output int n);
    n = 0;
    while (n < max) begin
      tick();
      n++;
      if (rom_addr == target) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] spk;
    logic [7:0]  addr;
    logic [7:0]  note;
    int          bl;
    int          n;
    int          hi;

    rst = 1'b1;
    play = 1'b0;
    restart = 1'b0;
    loop = 1'b0;
    repeat (3) tick();
    chk("rst_addr", rom_addr, 0);
    chk("rst_spk", speaker, 0);
    chk("rst_note", cur_note, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // one full non-looping pass
    done_seen = 0;
    play = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cap_step(spk, addr, note, bl);
      chk($sformatf("s%0d_addr", k), addr, k);
      chk($sformatf("s%0d_note", k), note, exp_note[k]);
      chk($sformatf("s%0d_spk", k), spk, exp_spk[k]);
      chk($sformatf("s%0d_busy", k), bl, 0);
    end
    tick();
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    play = 1'b0;
    tick();
    chk("done_clear", done, 0);
    chk("end_addr", rom_addr, 0);
    chk("end_note", cur_note, 0);
    chk("end_busy", busy, 0);
    chk("done_count", done_seen, 1);

    // looping
    do_reset();
    loop = 1'b1;
    play = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      cap_step(spk, addr, note, bl);
      chk($sformatf("loop%0d_addr", k), addr, k % 4);
    end
    chk("loop_no_done", done_seen, 0);

    // pause at step_cnt 7 of step 0
    do_reset();
    play = 1'b1;
    repeat (10) tick();
    chk("pre_pause_busy", busy, 1);
    play = 1'b0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (speaker !== 1'b0) hi++;
    end
    chk("pause_spk", hi, 0);
    chk("pause_note", cur_note, 33);
    chk("pause_addr", rom_addr, 0);
    play = 1'b1;
    tick();
    tick();
    chk("resume_spk", speaker, 1);
    wait_addr(8'd1, 40, n);
    chk("resume_len", n + 2, 13);

    wait_addr(8'd2, 40, n);
    chk("step_period", n, 22);

    // restart mid-step 2
    repeat (4) tick();
    chk("pre_restart_spk", speaker, 1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_addr", rom_addr, 0);
    chk("restart_spk", speaker, 0);
    chk("restart_busy", busy, 1);
    tick();
    tick();
    chk("restart_note", cur_note, 33);

    // rst mid-note wins over restart
    wait_addr(8'd2, 60, n);
    chk("reach_addr2", rom_addr, 2);
    repeat (4) tick();
    chk("pre_rst_spk", speaker, 1);
    rst = 1'b1;
    restart = 1'b1;
    tick();
    chk("mid_rst_addr", rom_addr, 0);
    chk("mid_rst_spk", speaker, 0);
    chk("mid_rst_note", cur_note, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    rst = 1'b0;
    restart = 1'b0;
    play = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/music_player.md
Name: music_player

Overview:
- Sequencer and tone generator downstream of the music note ROM. It also drives that ROM's address.
- Steps through song addresses at a fixed tempo and captures each registered note code.
- Converts each code to a square-wave half-period and drives the 1-bit speaker/buzzer pin.
- Supports play/pause, restart and loop for the game's background music.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; used only by the offline-generated pitch table.
- TICKS_PER_STEP, 6_250_000, clock cycles per song step (125 ms at 50 MHz).
- GAP_TICKS, 500_000, silent cycles at the end of every step (note articulation); must be < TICKS_PER_STEP.
- SONG_LEN, 176, number of ROM steps played; addresses 0..SONG_LEN-1; 1..256.
- ADDR_W, 8, ROM address width.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- play, in, 1, level; 1 = run, 0 = pause (hold position, speaker silent).
- restart, in, 1, single-cycle pulse; jump to address 0 and start playing.
- loop, in, 1, level; 1 = wrap to address 0 after the last step.
- rom_addr, out, ADDR_W, address to the note ROM.
- rom_note, in, 8, registered ROM output; valid 1 cycle after rom_addr changes.
- speaker, out, 1, square-wave tone output.
- cur_note, out, 8, note code currently sounding (0 = rest).
- busy, out, 1, high in FETCH/WAIT/PLAY.
- done, out, 1, single-cycle pulse when a non-looping song ends.

Behaviour:
- Reset values: rom_addr=0, speaker=0, cur_note=0, busy=0, done=0; state IDLE; all counters 0.
- Note code: 0 = rest. Code n in 1..127 gives frequency 261.63 Hz * 2^((n-33)/18), so 33 = C4 and 51 = C5.
- Codes 128..255 are treated as rest.
- half_period[n] = round(CLK_HZ / (2*f(n))), 20-bit unsigned, from a constant LUT; entry 0 = 0.
- FSM states:
  - IDLE: speaker=0, busy=0. Leave on restart, or on play=1 → FETCH with rom_addr=0.
  - FETCH: rom_addr already holds the step address; wait 1 cycle → WAIT.
  - WAIT: rom_note is valid. Register cur_note<=rom_note and hp<=half_period[rom_note]; clear step_cnt, tone_cnt and speaker → PLAY.
  - PLAY:
    - step_cnt increments every cycle while play=1.
    - Tone (when hp≠0 and step_cnt < TICKS_PER_STEP-GAP_TICKS): tone_cnt increments; at tone_cnt==hp-1, toggle speaker and clear tone_cnt.
    - Otherwise (gap window or rest), speaker=0 and tone_cnt holds 0.
    - At step_cnt==TICKS_PER_STEP-1:
      - If rom_addr < SONG_LEN-1: rom_addr+1 → FETCH.
      - Else if loop=1: rom_addr=0 → FETCH.
      - Else → DONE.
  - DONE: done=1 for exactly 1 cycle, cur_note=0, speaker=0 → IDLE with rom_addr=0.
- Per-step latency: 2 overhead cycles (FETCH, WAIT), so step period = TICKS_PER_STEP+2 cycles.
- Pause (play=0 in PLAY): step_cnt and tone_cnt hold, speaker forced 0, cur_note kept.
  - Resuming continues mid-step; the speaker phase restarts at 0.
  - play=0 in FETCH/WAIT does not stall; the FSM proceeds into PLAY and then pauses.
- restart in any state, including mid-step or DONE: next cycle rom_addr=0, speaker=0, state FETCH.
  - restart has priority over play=0 and over step completion in the same cycle.
  - restart in the DONE cycle suppresses the done pulse.
- rst has priority over everything and acts mid-note.
- Pitch-change arithmetic: tone_cnt compared against the registered hp; no division in hardware.
- rom_addr increment is ADDR_W bits. The SONG_LEN==256 wrap relies on the compare, not on overflow.

Decomposition:
- Package music_pkg holds:
  - NOTE_REST=8'd0, HP_W=20, typedef hp_t (logic [HP_W-1:0]);
  - state enum (IDLE, FETCH, WAIT, PLAY, DONE);
  - constant function/array HALF_PERIOD[0:255], generated offline from CLK_HZ=50 MHz.
- One sub-module, note_tone_gen:
  - inputs: clk, rst, en, hp;
  - output: speaker;
  - contains tone_cnt and the toggle logic.
- music_player keeps the FSM, step counter, address logic and LUT lookup.

Test Plan:
- Bench setup: TICKS_PER_STEP=20, GAP_TICKS=4, SONG_LEN=4, a behavioural registered-ROM model {33,0,51,33}, and HALF_PERIOD overridden so code 33→3 and 51→2.
- Reset, then play=1 → rom_addr 0,1,2,3 every 22 cycles; cur_note 33,0,51,33; one done pulse after step 3; busy falls; rom_addr back to 0.
- Code 33 step → speaker toggles every 3 cycles for 16 cycles, then is 0 for the 4 gap cycles. Rest step → speaker=0 for all 22 cycles.
- loop=1 → after address 3, rom_addr returns to 0 with no done pulse; the address sequence repeats indefinitely.
- play=0 for 10 cycles at step_cnt=7 → speaker 0 and counters frozen; after resume, the step ends 13 cycles later.
- restart pulse during step 2 → next cycle rom_addr=0 and speaker=0; cur_note=33 two cycles later.
- rst asserted mid-PLAY → all outputs at reset values next cycle; a simultaneous restart is ignored.
